// File: rtl/input_repeat.sv
// input_repeat: turns raw held-key levels into single-cycle action pulses.
// Left/right auto-repeat with a delay phase and mutual lockout. Down repeats
// at a fixed rate. Rotate, drop and hold pulse once per press. freeze
// suppresses everything and disarms any key that is still held.
module input_repeat #(
  parameter int unsigned DAS_CYCLES  = 16_000_000,
  parameter int unsigned ARR_CYCLES  = 5_000_000,
  parameter int unsigned SOFT_CYCLES = 3_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_down,
  input  logic btn_rot_cw,
  input  logic btn_rot_ccw,
  input  logic btn_drop,
  input  logic btn_hold,
  input  logic freeze,
  output logic key_left,
  output logic key_right,
  output logic key_down,
  output logic key_rotate_cw,
  output logic key_rotate_ccw,
  output logic key_drop,
  output logic key_hold,
  output logic key_drop_held
);

  // Key index map: 0 left, 1 right, 2 down, 3 rot_cw, 4 rot_ccw, 5 drop, 6 hold.
  localparam int NKEYS = 7;

  // Counters reload to 0 on a pulse, so the pulse is due when the count
  // reaches the period minus one.
  localparam logic [31:0] DAS_LAST  = 32'(DAS_CYCLES - 1);
  localparam logic [31:0] ARR_LAST  = 32'(ARR_CYCLES - 1);
  localparam logic [31:0] SOFT_LAST = 32'(SOFT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT,
    S_LOCKED
  } dir_state_t;

  typedef enum logic {
    D_IDLE,
    D_ACTIVE
  } down_state_t;

  logic [NKEYS-1:0] btn;
  logic [NKEYS-1:0] prev_reg;
  logic [NKEYS-1:0] disarm_reg;
  logic [NKEYS-1:0] press;
  logic [1:0]       dir_pulse;
  logic [6:3]       oneshot_pulse;

  assign btn = {btn_hold, btn_drop, btn_rot_ccw, btn_rot_cw,
                btn_down, btn_right, btn_left};

  // A press is a rising sample on an armed key.
  assign press = btn & ~prev_reg & ~disarm_reg;

  // Previous-sample and disarm tracking: a key held while frozen stays
  // disarmed until it is seen released.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg   <= '0;
      disarm_reg <= '0;
    end else begin
      prev_reg <= btn;
      if (freeze) begin
        disarm_reg <= btn;
      end else begin
        disarm_reg <= disarm_reg & btn;
      end
    end
  end

  // Left (gi=0) and right (gi=1) auto-repeat machines. A fresh press on
  // one side locks the other side out until that side is released.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dir
      localparam int OTHER = 1 - gi;

      dir_state_t  dir_state_reg;
      logic [31:0] dir_cnt_reg;
      logic        dir_pulse_reg;

      // IDLE -> DELAY -> REPEAT, with LOCKED on a conflicting press.
      always_ff @(posedge clk) begin
        if (rst || freeze) begin
          dir_state_reg <= S_IDLE;
          dir_cnt_reg   <= '0;
          dir_pulse_reg <= 1'b0;
        end else begin
          dir_pulse_reg <= 1'b0;
          if (!btn[gi]) begin
            dir_state_reg <= S_IDLE;
            dir_cnt_reg   <= '0;
          end else if (press[gi] && press[OTHER]) begin
            dir_state_reg <= S_LOCKED;
            dir_cnt_reg   <= '0;
          end else if (press[gi]) begin
            dir_pulse_reg <= 1'b1;
            dir_state_reg <= S_DELAY;
            dir_cnt_reg   <= '0;
          end else if (press[OTHER]) begin
            dir_state_reg <= S_LOCKED;
            dir_cnt_reg   <= '0;
          end else begin
            case (dir_state_reg)
              S_DELAY: begin
                if (dir_cnt_reg == DAS_LAST) begin
                  dir_pulse_reg <= 1'b1;
                  dir_state_reg <= S_REPEAT;
                  dir_cnt_reg   <= '0;
                end else begin
                  dir_cnt_reg <= dir_cnt_reg + 32'd1;
                end
              end
              S_REPEAT: begin
                if (dir_cnt_reg == ARR_LAST) begin
                  dir_pulse_reg <= 1'b1;
                  dir_cnt_reg   <= '0;
                end else begin
                  dir_cnt_reg <= dir_cnt_reg + 32'd1;
                end
              end
              default: begin
                // IDLE with a disarmed key, or LOCKED: wait for release.
                dir_cnt_reg <= '0;
              end
            endcase
          end
        end
      end

      assign dir_pulse[gi] = dir_pulse_reg;
    end
  endgenerate

  down_state_t down_state_reg;
  logic [31:0] down_cnt_reg;
  logic        down_pulse_reg;

  // Soft drop: pulse on press, then at a fixed rate while held.
  always_ff @(posedge clk) begin
    if (rst || freeze) begin
      down_state_reg <= D_IDLE;
      down_cnt_reg   <= '0;
      down_pulse_reg <= 1'b0;
    end else begin
      down_pulse_reg <= 1'b0;
      if (!btn[2]) begin
        down_state_reg <= D_IDLE;
        down_cnt_reg   <= '0;
      end else if (press[2]) begin
        down_pulse_reg <= 1'b1;
        down_state_reg <= D_ACTIVE;
        down_cnt_reg   <= '0;
      end else if (down_state_reg == D_ACTIVE) begin
        if (down_cnt_reg == SOFT_LAST) begin
          down_pulse_reg <= 1'b1;
          down_cnt_reg   <= '0;
        end else begin
          down_cnt_reg <= down_cnt_reg + 32'd1;
        end
      end
    end
  end

  // Rotate, drop and hold: exactly one pulse per press, no repeat.
  generate
    for (genvar gi = 3; gi < NKEYS; gi++) begin : g_oneshot
      logic oneshot_reg;

      // Registered press pulse, silenced while frozen.
      always_ff @(posedge clk) begin
        if (rst || freeze) begin
          oneshot_reg <= 1'b0;
        end else begin
          oneshot_reg <= press[gi];
        end
      end

      assign oneshot_pulse[gi] = oneshot_reg;
    end
  endgenerate

  logic drop_held_reg;

  // Level copy of the drop button for hard-drop hold detection.
  always_ff @(posedge clk) begin
    if (rst || freeze) begin
      drop_held_reg <= 1'b0;
    end else begin
      drop_held_reg <= btn_drop;
    end
  end

  assign key_left       = dir_pulse[0];
  assign key_right      = dir_pulse[1];
  assign key_down       = down_pulse_reg;
  assign key_rotate_cw  = oneshot_pulse[3];
  assign key_rotate_ccw = oneshot_pulse[4];
  assign key_drop       = oneshot_pulse[5];
  assign key_hold       = oneshot_pulse[6];
  assign key_drop_held  = drop_held_reg;

endmodule

// File: tb/tb_input_repeat.sv
// Directed bench for input_repeat with small timing parameters. Each step
// drives one sampling edge and pushes the expected output vector, which is
// popped and compared once the registered outputs settle.
module tb_input_repeat;

  localparam int DAS  = 8;
  localparam int ARR  = 3;
  localparam int SOFT = 2;

  // Button vector bits: {hold, drop, ccw, cw, down, right, left}
  localparam logic [6:0] B_L   = 7'b0000001;
  localparam logic [6:0] B_R   = 7'b0000010;
  localparam logic [6:0] B_D   = 7'b0000100;
  localparam logic [6:0] B_CW  = 7'b0001000;
  localparam logic [6:0] B_CCW = 7'b0010000;
  localparam logic [6:0] B_DR  = 7'b0100000;
  localparam logic [6:0] B_H   = 7'b1000000;
  // Output vector bits: {drop_held, hold, drop, ccw, cw, down, right, left}
  localparam logic [7:0] K_L   = 8'b00000001;
  localparam logic [7:0] K_R   = 8'b00000010;
  localparam logic [7:0] K_D   = 8'b00000100;
  localparam logic [7:0] K_CW  = 8'b00001000;
  localparam logic [7:0] K_CCW = 8'b00010000;
  localparam logic [7:0] K_DR  = 8'b00100000;
  localparam logic [7:0] K_H   = 8'b01000000;
  localparam logic [7:0] K_DH  = 8'b10000000;

  logic clk = 1'b0;
  logic rst, freeze;
  logic btn_left, btn_right, btn_down, btn_rot_cw, btn_rot_ccw, btn_drop, btn_hold;
  logic key_left, key_right, key_down, key_rotate_cw, key_rotate_ccw;
  logic key_drop, key_hold, key_drop_held;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  input_repeat #(
    .DAS_CYCLES (DAS),
    .ARR_CYCLES (ARR),
    .SOFT_CYCLES(SOFT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_down      (btn_down),
    .btn_rot_cw    (btn_rot_cw),
    .btn_rot_ccw   (btn_rot_ccw),
    .btn_drop      (btn_drop),
    .btn_hold      (btn_hold),
    .freeze        (freeze),
    .key_left      (key_left),
    .key_right     (key_right),
    .key_down      (key_down),
    .key_rotate_cw (key_rotate_cw),
    .key_rotate_ccw(key_rotate_ccw),
    .key_drop      (key_drop),
    .key_hold      (key_hold),
    .key_drop_held (key_drop_held)
  );

  // Left/right repeat schedule relative to the press edge.
  function automatic bit lr_due(input int k);
    return (k == 0) || (k >= DAS && ((k - DAS) % ARR) == 0);
  endfunction

  // One sampling edge: drive, push expectation, then pop and compare.
  task automatic step(input string tag, input logic r, input logic f,
                      input logic [6:0] b, input logic [7:0] e);
    logic [7:0] got;
    logic [7:0] want;
    @(negedge clk);
    rst    = r;
    freeze = f;
    {btn_hold, btn_drop, btn_rot_ccw, btn_rot_cw, btn_down, btn_right, btn_left} = b;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got  = {key_drop_held, key_hold, key_drop, key_rotate_ccw, key_rotate_cw,
            key_down, key_right, key_left};
    want = exp_q.pop_front();
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, got, want);
    end
    $display("step %-18s rst=%b frz=%b btn=%b out=%b", tag, r, f, b, got);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 1'b0, 1'b0, 7'd0, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; freeze = 1'b0;
    btn_left = 0; btn_right = 0; btn_down = 0; btn_rot_cw = 0;
    btn_rot_ccw = 0; btn_drop = 0; btn_hold = 0;

    // Reset state, then a key held through reset release is a fresh press.
    step("reset0", 1'b1, 1'b0, 7'd0, 8'd0);
    step("reset_hold_l", 1'b1, 1'b0, B_L, 8'd0);
    step("reset_rel_l", 1'b0, 1'b0, B_L, K_L);
    idle(2);

    // Left held 20 edges: pulses at 0, 8, 11, 14, 17; due at 20 but released.
    for (int k = 0; k < 20; k++)
      step($sformatf("left_e%0d", k), 1'b0, 1'b0, B_L, lr_due(k) ? K_L : 8'd0);
    for (int k = 20; k < 23; k++) step($sformatf("left_rel_e%0d", k), 1'b0, 1'b0, 7'd0, 8'd0);

    // Right pressed at edge 4 with left held: right repeats, left locked.
    for (int k = 0; k <= 20; k++) begin
      logic [7:0] e;
      e = (k == 0) ? K_L : 8'd0;
      if (k >= 4 && lr_due(k - 4)) e = e | K_R;
      step($sformatf("conf_e%0d", k), 1'b0, 1'b0, (k >= 4) ? (B_L | B_R) : B_L, e);
    end
    for (int k = 21; k < 24; k++) step($sformatf("conf_lonly_e%0d", k), 1'b0, 1'b0, B_L, 8'd0);
    idle(2);

    // Down held 7 edges: pulses at 0, 2, 4, 6.
    for (int k = 0; k < 7; k++)
      step($sformatf("down_e%0d", k), 1'b0, 1'b0, B_D, (k % SOFT == 0) ? K_D : 8'd0);
    step("down_rel", 1'b0, 1'b0, 7'd0, 8'd0);

    // Rotate cw held 10 edges: a single pulse.
    for (int k = 0; k < 10; k++)
      step($sformatf("cw_e%0d", k), 1'b0, 1'b0, B_CW, (k == 0) ? K_CW : 8'd0);
    idle(1);

    // Drop held edges 0-5: one pulse, held level follows for those cycles.
    for (int k = 0; k < 6; k++)
      step($sformatf("drop_e%0d", k), 1'b0, 1'b0, B_DR, (k == 0) ? (K_DR | K_DH) : K_DH);
    step("drop_rel", 1'b0, 1'b0, 7'd0, 8'd0);

    // Drop pressed under freeze: no pulse, held level gated, disarmed after.
    step("drop_frz", 1'b0, 1'b1, B_DR, 8'd0);
    step("drop_unfrz", 1'b0, 1'b0, B_DR, K_DH);
    idle(1);

    // Simultaneous one-shot presses each pulse.
    step("multi_press", 1'b0, 1'b0, B_CCW | B_H | B_CW, K_CCW | K_H | K_CW);
    step("multi_held", 1'b0, 1'b0, B_CCW | B_H | B_CW, 8'd0);
    idle(1);

    // Freeze from edge 5 to 9 with left held; re-press required afterwards.
    for (int k = 0; k < 15; k++)
      step($sformatf("frz_e%0d", k), 1'b0, (k >= 5 && k < 10), B_L, (k == 0) ? K_L : 8'd0);
    step("frz_rel", 1'b0, 1'b0, 7'd0, 8'd0);
    step("frz_repress", 1'b0, 1'b0, B_L, K_L);
    idle(1);

    // Left and right at the same edge: both locked, no pulses.
    for (int k = 0; k < 4; k++)
      step($sformatf("both_e%0d", k), 1'b0, 1'b0, B_L | B_R, 8'd0);
    step("both_rel", 1'b0, 1'b0, 7'd0, 8'd0);
    step("both_left_only", 1'b0, 1'b0, B_L, K_L);
    idle(1);

    // Reset mid-repeat at an edge where a pulse is due: nothing trails.
    for (int k = 0; k < 11; k++)
      step($sformatf("rstmid_e%0d", k), 1'b0, 1'b0, B_L, lr_due(k) ? K_L : 8'd0);
    step("rstmid_due", 1'b1, 1'b0, B_L, 8'd0);
    step("rstmid_hold", 1'b1, 1'b0, B_L, 8'd0);
    step("rstmid_fresh", 1'b0, 1'b0, B_L, K_L);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_repeat.md
INPUT_REPEAT -- requirements
Module: input_repeat

Interface
REQ-001 Parameter DAS_CYCLES, default 16_000_000, clk cycles from the initial left/right pulse to the first auto-repeat pulse (160 ms at 100 MHz).
REQ-002 Parameter ARR_CYCLES, default 5_000_000, clk cycles between consecutive left/right auto-repeat pulses.
REQ-003 Parameter SOFT_CYCLES, default 3_000_000, clk cycles between consecutive soft-drop (down) pulses.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset: clk input 1 bit, system clock; rst input 1 bit, synchronous active-high reset.
REQ-005 btn_left, btn_right, btn_down, btn_rot_cw, btn_rot_ccw, btn_drop, btn_hold: each an input, 1 bit, raw held-key level from the keyboard decoder, already synchronous to clk.
REQ-006 freeze: input, 1 bit; high suppresses all outputs (game over or pause).
REQ-007 key_left, key_right, key_down, key_rotate_cw, key_rotate_ccw, key_drop, key_hold: each an output, 1 bit, single-cycle registered action pulse feeding game_control.
REQ-008 key_drop_held: output, 1 bit, registered copy of btn_drop gated by freeze.

Function
REQ-009 A press SHALL be a clk edge at which btn_x samples 1 and the previous sample of btn_x was 0; pulse outputs are registered and assert for exactly one cycle after the sampling edge.
REQ-010 Left/right each SHALL use a state machine IDLE -> DELAY -> REPEAT with a 32-bit counter; a press emits a pulse at press edge E and enters DELAY.
REQ-011 In DELAY while held: pulse at edge E+DAS_CYCLES, then enter REPEAT; in REPEAT: pulse every ARR_CYCLES edges (E+DAS+ARR, E+DAS+2*ARR, ...).
REQ-012 Release (btn_x sampled 0) in any state SHALL return to IDLE at that edge with no pulse, even if a repeat was due at that edge.
REQ-013 Left/right conflict: a press on one direction while the other is held SHALL pulse the new direction and force the other to a LOCKED state; LOCKED emits nothing until its button is released (then IDLE).
REQ-014 Simultaneous left and right presses at the same edge SHALL emit no pulse on either; both enter LOCKED.
REQ-015 Down SHALL pulse at press edge E and then every SOFT_CYCLES edges while held (no DAS phase); release returns it to IDLE.
REQ-016 rot_cw, rot_ccw, drop, hold SHALL emit exactly one pulse per press, with no repeat; simultaneous presses of different keys each pulse independently.
REQ-017 key_drop_held SHALL equal btn_drop delayed one cycle, forced 0 while freeze is sampled high.
REQ-018 While freeze is sampled 1: all pulse outputs SHALL be 0, all state machines SHALL be IDLE, and counters SHALL be cleared.
REQ-019 After freeze falls, a key still held SHALL produce no pulse until it is released and pressed again; one disarm bit per key SHALL implement this.
REQ-020 Counters SHALL never wrap; each counter reloads on every pulse and is cleared on entry to IDLE.

Reset
REQ-021 With rst sampled 1: all outputs SHALL be 0, all state machines SHALL be IDLE, and counters, disarm bits and previous-sample registers SHALL be 0.
REQ-022 A button held through reset release SHALL be treated as a fresh press at the first edge after rst falls.
REQ-023 Reset asserted mid-repeat SHALL take effect at the next edge with no trailing pulse.

Verification (DAS_CYCLES=8, ARR_CYCLES=3, SOFT_CYCLES=2)
REQ-024 Hold btn_left for 20 cycles from edge 0 -> key_left pulses after edges 0, 8, 11, 14, 17 only; after release no pulse.
REQ-025 Hold btn_left; press btn_right at edge 4, hold both to edge 20 -> key_right pulses after edges 4, 12, 15, 18; key_left pulses only after edge 0; release right with left held -> no key_left.
REQ-026 Hold btn_down for 7 cycles from edge 0 -> key_down pulses after edges 0, 2, 4, 6; btn_rot_cw held for 10 cycles -> exactly one key_rotate_cw pulse.
REQ-027 btn_drop high for edges 0-5 -> one key_drop pulse after edge 0; key_drop_held high for the cycles after edges 0-5.
REQ-028 Raise freeze at edge 5 with btn_left held, drop freeze at edge 10 -> no key_left pulses after edges 5-onward until release plus re-press, which pulses on the re-press edge.
REQ-029 Left and right pressed at the same edge -> no pulses on either; release both, then press left alone -> pulse on that edge.
